// File: rtl/mf_cmac_engine_pkg.sv
// Shared constants, FSM state type and output saturation helper for the
// complex matched-filter correlator (saturation is used only under MF_SAT_EN).
package mf_cmac_engine_pkg;

    localparam int TAPS      = 61;
    localparam int DW        = 16;
    localparam int AW        = 32;
    localparam int ACCW      = 40;
    localparam int OUT_SHIFT = 15;
    localparam int PW        = 2 * DW;
    localparam int TW        = $clog2(TAPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Clamp to the signed DW range, result sign-extended to ACCW.
    function automatic logic signed [ACCW-1:0] sat_dw(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] max_v;
        logic signed [ACCW-1:0] min_v;
        max_v = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        min_v = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (a > max_v) begin
            return max_v;
        end else if (a < min_v) begin
            return min_v;
        end else begin
            return a;
        end
    endfunction

endpackage

// File: rtl/mf_cmac_engine_if.sv
// Sample input, coefficient ROM and result handshake bundle of mf_cmac_engine.
interface mf_cmac_engine_if;
    import mf_cmac_engine_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic signed [DW-1:0]   in_re;
    logic signed [DW-1:0]   in_im;
    logic                   coef_en;
    logic [AW-1:0]          coef_addr;
    logic signed [DW-1:0]   coef_re;
    logic signed [DW-1:0]   coef_im;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACCW-1:0] out_re;
    logic signed [ACCW-1:0] out_im;

    modport slave (
        input  in_valid, in_re, in_im, coef_re, coef_im, out_ready,
        output in_ready, coef_en, coef_addr, out_valid, out_re, out_im
    );

    modport master (
        output in_valid, in_re, in_im, coef_re, coef_im, out_ready,
        input  in_ready, coef_en, coef_addr, out_valid, out_re, out_im
    );

endinterface

// File: rtl/mf_cmac_engine_cmult.sv
// Registered complex-conjugate multiply-accumulate stage: acc += x * conj(c).
// The next accumulator value is exported so the final product lands in the result.
module mf_cmult
    import mf_cmac_engine_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   en,
    input  logic signed [DW-1:0]   x_re,
    input  logic signed [DW-1:0]   x_im,
    input  logic signed [DW-1:0]   c_re,
    input  logic signed [DW-1:0]   c_im,
    output logic signed [ACCW-1:0] acc_re_nxt,
    output logic signed [ACCW-1:0] acc_im_nxt
);

    logic signed [PW-1:0]   p_rr_s, p_ii_s, p_ir_s, p_ri_s;
    logic signed [ACCW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;

    assign p_rr_s = PW'(x_re) * PW'(c_re);
    assign p_ii_s = PW'(x_im) * PW'(c_im);
    assign p_ir_s = PW'(x_im) * PW'(c_re);
    assign p_ri_s = PW'(x_re) * PW'(c_im);

    // Next accumulator value: clear on a new sample, wrap-around accumulation otherwise.
    always_comb begin
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        if (clr) begin
            acc_re_d = '0;
            acc_im_d = '0;
        end else if (en) begin
            acc_re_d = acc_re_q + ACCW'(p_rr_s) + ACCW'(p_ii_s);
            acc_im_d = acc_im_q + ACCW'(p_ir_s) - ACCW'(p_ri_s);
        end else begin
            acc_re_d = acc_re_q;
            acc_im_d = acc_im_q;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    assign acc_re_nxt = acc_re_d;
    assign acc_im_nxt = acc_im_d;

endmodule

// File: rtl/mf_cmac_engine.sv
// Complex matched-filter correlator: sum over k of x[n-k]*conj(h[k]) per sample.
// Optional macro MF_SAT_EN: results shifted by OUT_SHIFT and saturated to DW bits.
module mf_cmac_engine
    import mf_cmac_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mf_cmac_engine_if.slave  bus
);

    state_e                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic                   coef_en_q, coef_en_d;
    logic [AW-1:0]          coef_addr_q, coef_addr_d;
    logic [TW-1:0]          tap_dly_q, tap_dly_d;
    logic                   vld_dly_q, vld_dly_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [ACCW-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
    logic signed [DW-1:0]   hist_re_q [TAPS];
    logic signed [DW-1:0]   hist_im_q [TAPS];
    logic signed [DW-1:0]   hist_re_d [TAPS];
    logic signed [DW-1:0]   hist_im_d [TAPS];
    logic                   acc_clr_s;
    logic signed [ACCW-1:0] acc_re_nxt_s, acc_im_nxt_s;

    // The tap index is delayed one cycle so hist[k] meets the ROM data for address k.
    mf_cmult u_cmult (
        .clk        (clk),
        .rst        (rst),
        .clr        (acc_clr_s),
        .en         (vld_dly_q),
        .x_re       (hist_re_q[tap_dly_q]),
        .x_im       (hist_im_q[tap_dly_q]),
        .c_re       (bus.coef_re),
        .c_im       (bus.coef_im),
        .acc_re_nxt (acc_re_nxt_s),
        .acc_im_nxt (acc_im_nxt_s)
    );

    // Sequencer next-state and output computation.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        coef_en_d   = coef_en_q;
        coef_addr_d = coef_addr_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        hist_re_d   = hist_re_q;
        hist_im_d   = hist_im_q;
        tap_dly_d   = coef_addr_q[TW-1:0];
        vld_dly_d   = coef_en_q;
        acc_clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        hist_re_d[k] = hist_re_q[k-1];
                        hist_im_d[k] = hist_im_q[k-1];
                    end
                    hist_re_d[0] = bus.in_re;
                    hist_im_d[0] = bus.in_im;
                    acc_clr_s    = 1'b1;
                    in_ready_d   = 1'b0;
                    coef_en_d    = 1'b1;
                    coef_addr_d  = '0;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (coef_addr_q == AW'(TAPS - 1)) begin
                    coef_en_d = 1'b0;
                    state_d   = ST_DRAIN;
                end else begin
                    coef_addr_d = coef_addr_q + 32'd1;
                end
            end
            ST_DRAIN: begin
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
`ifdef MF_SAT_EN
                out_re_d = sat_dw(acc_re_nxt_s >>> OUT_SHIFT);
                out_im_d = sat_dw(acc_im_nxt_s >>> OUT_SHIFT);
`else
                out_re_d = acc_re_nxt_s;
                out_im_d = acc_im_nxt_s;
`endif
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer, history and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            coef_en_q   <= 1'b0;
            coef_addr_q <= '0;
            tap_dly_q   <= '0;
            vld_dly_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            for (int k = 0; k < TAPS; k++) begin
                hist_re_q[k] <= '0;
                hist_im_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            coef_en_q   <= coef_en_d;
            coef_addr_q <= coef_addr_d;
            tap_dly_q   <= tap_dly_d;
            vld_dly_q   <= vld_dly_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            hist_re_q   <= hist_re_d;
            hist_im_q   <= hist_im_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.coef_en   = coef_en_q;
    assign bus.coef_addr = coef_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;

endmodule
